// File: rtl/centscale_sched.sv
// Four-channel round-robin scheduler for the shared center/scale datapath.
// Buffers one sample per channel, delays coefficients to the multipliers and tags results with their channel.
module centscale_sched #(
  parameter int          NCH      = 4,
  parameter int          LATENCY  = 18,
  parameter int          CONV_LAT = 5,
  parameter logic [31:0] STD_RST  = 32'h3F800000
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic [NCH*21-1:0] ch_x,
  input  logic [NCH-1:0]    ch_valid,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_ch,
  input  logic              cfg_sel,
  input  logic [31:0]       cfg_data,
  input  logic              ovf_clr,
  output logic [20:0]       dp_x_adc,
  output logic              dp_srdyi,
  output logic [31:0]       dp_mean,
  output logic [31:0]       dp_std,
  input  logic [31:0]       dp_x_centScale,
  input  logic              dp_srdyo,
  output logic [31:0]       y_o,
  output logic [1:0]        y_ch,
  output logic              y_valid,
  output logic [NCH-1:0]    overflow,
  output logic              err_sync
);

  // Channel index is 2 bits wide, so pointer arithmetic wraps mod NCH for free.
  localparam int CW = 2;

  logic [NCH-1:0]               pend_q, pend_d;
  logic [NCH-1:0][20:0]         buf_q, buf_d;
  logic [CW-1:0]                rr_q, rr_d;
  logic [NCH-1:0][31:0]         mean_q, mean_d, std_q, std_d;
  logic [20:0]                  x_adc_q, x_adc_d;
  logic                         srdyi_q, srdyi_d;
  logic [CW-1:0]                iss_ch_q, iss_ch_d;
  logic [CONV_LAT-1:0]          cdl_v_q, cdl_v_d;
  logic [CONV_LAT-1:0][31:0]    cdl_m_q, cdl_m_d, cdl_s_q, cdl_s_d;
  logic [31:0]                  dp_mean_q, dp_mean_d, dp_std_q, dp_std_d;
  logic [LATENCY-1:0]           tag_v_q, tag_v_d;
  logic [LATENCY-1:0][CW-1:0]   tag_c_q, tag_c_d;
  logic [31:0]                  y_o_q, y_o_d;
  logic [CW-1:0]                y_ch_q, y_ch_d;
  logic                         y_valid_q, y_valid_d;
  logic [NCH-1:0]               ovf_q, ovf_d, ovf_set;
  logic                         err_q, err_d;

  logic [NCH-1:0] req;
  logic           found;
  logic [CW-1:0]  win, idx;

  // A strobe arriving this cycle competes immediately, so an idle channel is issued without a buffer stop.
  always_comb begin
    req   = pend_q | ch_valid;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = rr_q + CW'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    pend_d  = pend_q;
    buf_d   = buf_q;
    ovf_set = '0;
    if (found) pend_d[win] = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_valid[i]) begin
        if (found && win == CW'(i)) begin
          if (pend_q[i]) begin
            buf_d[i]  = ch_x[21*i +: 21];
            pend_d[i] = 1'b1;
          end
        end else if (pend_q[i]) begin
          ovf_set[i] = 1'b1;
        end else begin
          buf_d[i]  = ch_x[21*i +: 21];
          pend_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    x_adc_d  = x_adc_q;
    rr_d     = rr_q;
    srdyi_d  = found;
    iss_ch_d = win;
    if (found) begin
      x_adc_d = pend_q[win] ? buf_q[win] : ch_x[21*int'(win) +: 21];
      rr_d    = win + CW'(1);
    end
  end

  // Issue reads the registers before this edge's write lands.
  always_comb begin
    mean_d = mean_q;
    std_d  = std_q;
    if (cfg_we) begin
      if (cfg_sel) std_d[cfg_ch]  = cfg_data;
      else         mean_d[cfg_ch] = cfg_data;
    end
  end

  always_comb begin
    cdl_v_d   = {cdl_v_q[CONV_LAT-2:0], found};
    cdl_m_d   = {cdl_m_q[CONV_LAT-2:0], mean_q[win]};
    cdl_s_d   = {cdl_s_q[CONV_LAT-2:0], std_q[win]};
    dp_mean_d = cdl_v_q[CONV_LAT-1] ? cdl_m_q[CONV_LAT-1] : dp_mean_q;
    dp_std_d  = cdl_v_q[CONV_LAT-1] ? cdl_s_q[CONV_LAT-1] : dp_std_q;
  end

  // Tag line starts from the registered issue so its tail lines up with dp_srdyo.
  always_comb begin
    tag_v_d   = {tag_v_q[LATENCY-2:0], srdyi_q};
    tag_c_d   = {tag_c_q[LATENCY-2:0], iss_ch_q};
    y_o_d     = dp_x_centScale;
    y_valid_d = dp_srdyo;
    y_ch_d    = tag_c_q[LATENCY-1];
    ovf_d     = (ovf_clr ? '0 : ovf_q) | ovf_set;
    err_d     = (ovf_clr ? 1'b0 : err_q) | (dp_srdyo != tag_v_q[LATENCY-1]);
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      pend_q    <= '0;
      buf_q     <= '0;
      rr_q      <= '0;
      mean_q    <= '0;
      std_q     <= {NCH{STD_RST}};
      x_adc_q   <= '0;
      srdyi_q   <= 1'b0;
      iss_ch_q  <= '0;
      cdl_v_q   <= '0;
      cdl_m_q   <= '0;
      cdl_s_q   <= '0;
      dp_mean_q <= '0;
      dp_std_q  <= '0;
      tag_v_q   <= '0;
      tag_c_q   <= '0;
      y_o_q     <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      ovf_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      buf_q     <= buf_d;
      rr_q      <= rr_d;
      mean_q    <= mean_d;
      std_q     <= std_d;
      x_adc_q   <= x_adc_d;
      srdyi_q   <= srdyi_d;
      iss_ch_q  <= iss_ch_d;
      cdl_v_q   <= cdl_v_d;
      cdl_m_q   <= cdl_m_d;
      cdl_s_q   <= cdl_s_d;
      dp_mean_q <= dp_mean_d;
      dp_std_q  <= dp_std_d;
      tag_v_q   <= tag_v_d;
      tag_c_q   <= tag_c_d;
      y_o_q     <= y_o_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign dp_x_adc = x_adc_q;
  assign dp_srdyi = srdyi_q;
  assign dp_mean  = dp_mean_q;
  assign dp_std   = dp_std_q;
  assign y_o      = y_o_q;
  assign y_ch     = y_ch_q;
  assign y_valid  = y_valid_q;
  assign overflow = ovf_q;
  assign err_sync = err_q;

endmodule

// File: tb/tb_centscale_sched.sv
// Bench for centscale_sched: directed scenarios plus random traffic against a cycle-indexed reference model.
// The bench also plays the datapath, returning a tagged word LATENCY cycles after each modelled issue.
module tb_centscale_sched;
  localparam int          NCH     = 4;
  localparam int          LAT     = 18;
  localparam int          CLAT    = 5;
  localparam logic [31:0] STD_RST = 32'h3F800000;

  logic              clk = 1'b0;
  logic              GlobalReset = 1'b1;
  logic [NCH*21-1:0] ch_x = '0;
  logic [NCH-1:0]    ch_valid = '0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_ch = '0;
  logic              cfg_sel = 1'b0;
  logic [31:0]       cfg_data = '0;
  logic              ovf_clr = 1'b0;
  logic [20:0]       dp_x_adc;
  logic              dp_srdyi;
  logic [31:0]       dp_mean, dp_std;
  logic [31:0]       dp_x_centScale = '0;
  logic              dp_srdyo = 1'b0;
  logic [31:0]       y_o;
  logic [1:0]        y_ch;
  logic              y_valid;
  logic [NCH-1:0]    overflow;
  logic              err_sync;

  always #5 clk = ~clk;

  centscale_sched dut (
    .clk(clk), .GlobalReset(GlobalReset), .ch_x(ch_x), .ch_valid(ch_valid),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .ovf_clr(ovf_clr), .dp_x_adc(dp_x_adc), .dp_srdyi(dp_srdyi),
    .dp_mean(dp_mean), .dp_std(dp_std), .dp_x_centScale(dp_x_centScale),
    .dp_srdyo(dp_srdyo), .y_o(y_o), .y_ch(y_ch), .y_valid(y_valid),
    .overflow(overflow), .err_sync(err_sync)
  );

  int n_vec = 0, n_bad = 0, cyc = 0;
  bit inj = 1'b0;

  // Reference state: what the channels hold, and what each output must show next cycle.
  bit          pend_m[NCH];
  logic [20:0] buf_m[NCH];
  int          rr_m;
  logic [31:0] mean_m[NCH], std_m[NCH];
  logic [31:0] due_mean[int], due_std[int], res_val[int];
  logic [1:0]  res_ch[int];
  logic [33:0] exp_q[$];
  logic [20:0] e_x;
  logic        e_srdyi, e_yv, e_err, e_ych_ok;
  logic [31:0] e_mean, e_std, e_yo;
  logic [NCH-1:0] e_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [20:0] slice(input int i);
    logic [NCH*21-1:0] v;
    v = ch_x;
    return v[21*i +: 21];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      pend_m[i] = 1'b0; buf_m[i] = '0; mean_m[i] = '0; std_m[i] = STD_RST;
    end
    rr_m = 0;
    due_mean.delete(); due_std.delete(); res_val.delete(); res_ch.delete();
    exp_q.delete();
    e_x = '0; e_srdyi = 0; e_yv = 0; e_err = 0; e_ych_ok = 0;
    e_mean = '0; e_std = '0; e_yo = '0; e_ovf = '0;
  endtask

  task automatic drive_dp();
    dp_srdyo       = res_ch.exists(cyc) || inj;
    dp_x_centScale = res_val.exists(cyc) ? res_val[cyc] : (inj ? 32'hDEADBEEF : 32'h0);
  endtask

  task automatic model_edge();
    int w;
    bit was_pend[NCH];
    logic [20:0] x;
    logic [31:0] f;
    logic [NCH-1:0] ovf_evt;
    if (GlobalReset) begin
      model_reset();
      return;
    end
    e_yv     = dp_srdyo;
    e_yo     = dp_x_centScale;
    e_ych_ok = res_ch.exists(cyc);
    e_err    = (ovf_clr ? 1'b0 : e_err) | (dp_srdyo != res_ch.exists(cyc));
    w = -1;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (rr_m + k) % NCH;
      if (w < 0 && (pend_m[c] || ch_valid[c])) w = c;
    end
    for (int i = 0; i < NCH; i++) was_pend[i] = pend_m[i];
    ovf_evt = '0;
    if (w >= 0) begin
      x = was_pend[w] ? buf_m[w] : slice(w);
      f = {3'b101, 8'(w), x};
      e_srdyi = 1'b1;
      e_x     = x;
      due_mean[cyc+1+CLAT] = mean_m[w];
      due_std[cyc+1+CLAT]  = std_m[w];
      res_val[cyc+1+LAT]   = f;
      res_ch[cyc+1+LAT]    = w[1:0];
      exp_q.push_back({w[1:0], f});
      pend_m[w] = 1'b0;
      rr_m = (w + 1) % NCH;
    end else begin
      e_srdyi = 1'b0;
    end
    for (int i = 0; i < NCH; i++) begin
      if (ch_valid[i]) begin
        if (i == w) begin
          if (was_pend[i]) begin buf_m[i] = slice(i); pend_m[i] = 1'b1; end
        end else if (was_pend[i]) begin
          ovf_evt[i] = 1'b1;
        end else begin
          buf_m[i] = slice(i); pend_m[i] = 1'b1;
        end
      end
    end
    if (cfg_we) begin
      if (cfg_sel) std_m[cfg_ch] = cfg_data;
      else         mean_m[cfg_ch] = cfg_data;
    end
    e_ovf = (ovf_clr ? '0 : e_ovf) | ovf_evt;
    if (due_mean.exists(cyc+1)) begin
      e_mean = due_mean[cyc+1];
      e_std  = due_std[cyc+1];
    end
  endtask

  task automatic check_all();
    logic [33:0] e;
    chk("dp_srdyi", {31'b0, dp_srdyi}, {31'b0, e_srdyi});
    chk("dp_x_adc", {11'b0, dp_x_adc}, {11'b0, e_x});
    chk("dp_mean", dp_mean, e_mean);
    chk("dp_std", dp_std, e_std);
    chk("y_valid", {31'b0, y_valid}, {31'b0, e_yv});
    chk("y_o", y_o, e_yo);
    chk("overflow", {28'b0, overflow}, {28'b0, e_ovf});
    chk("err_sync", {31'b0, err_sync}, {31'b0, e_err});
    if (e_yv && e_ych_ok) begin
      if (exp_q.size() == 0) chk("sb_empty", 32'd0, 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("y_ch", {30'b0, y_ch}, {30'b0, e[33:32]});
        chk("y_word", y_o, e[31:0]);
      end
    end
  endtask

  task automatic step();
    drive_dp();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    ch_valid = '0; cfg_we = 1'b0; ovf_clr = 1'b0; inj = 1'b0;
  endtask

  task automatic do_reset();
    GlobalReset = 1'b1;
    step();
    step();
    GlobalReset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [20:0] xs[NCH];
    model_reset();
    do_reset();

    // Single sample after reset
    ch_x = {$urandom, $urandom, $urandom};
    ch_valid = 4'b0001;
    step();
    chk("t1_srdyi", {31'b0, dp_srdyi}, 32'd1);
    idle(5);
    chk("t1_std", dp_std, 32'h3F800000);
    chk("t1_mean", dp_mean, 32'h0);
    idle(14);
    chk("t1_yvalid", {31'b0, y_valid}, 32'd1);
    chk("t1_ych", {30'b0, y_ch}, 32'd0);

    // Two bursts on all channels
    do_reset();
    for (int b = 0; b < 2; b++) begin
      ch_x = {$urandom, $urandom, $urandom};
      for (int i = 0; i < NCH; i++) xs[i] = slice(i);
      ch_valid = 4'b1111;
      for (int i = 0; i < NCH; i++) begin
        step();
        chk("burst_order", {11'b0, dp_x_adc}, {11'b0, xs[i]});
      end
      step();
    end
    idle(LAT + 2);

    // Overflow on channel 3
    do_reset();
    ch_x = {$urandom, $urandom, $urandom};
    xs[3] = slice(3);
    ch_valid = 4'b1111;
    step();
    ch_x = {$urandom, $urandom, $urandom};
    ch_valid = 4'b1000;
    step();
    chk("ovf_set", {28'b0, overflow}, 32'h8);
    idle(2);
    chk("ovf_first_kept", {11'b0, dp_x_adc}, {11'b0, xs[3]});
    idle(3);
    ovf_clr = 1'b1;
    step();
    chk("ovf_clr", {28'b0, overflow}, 32'h0);
    idle(LAT);

    // Coefficient write in the issue cycle of channel 1
    do_reset();
    ch_x = {$urandom, $urandom, $urandom};
    ch_valid = 4'b0010;
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_sel = 1'b1; cfg_data = 32'h40000000;
    step();
    idle(CLAT);
    chk("cfg_old_std", dp_std, 32'h3F800000);
    ch_valid = 4'b0010;
    step();
    idle(CLAT);
    chk("cfg_new_std", dp_std, 32'h40000000);
    idle(LAT);

    // Spurious datapath valid
    do_reset();
    inj = 1'b1;
    step();
    chk("err_set", {31'b0, err_sync}, 32'd1);
    idle(3);
    chk("err_sticky", {31'b0, err_sync}, 32'd1);
    ovf_clr = 1'b1;
    step();
    chk("err_clr", {31'b0, err_sync}, 32'd0);

    // Reset with samples in flight
    do_reset();
    ch_x = {$urandom, $urandom, $urandom};
    ch_valid = 4'b1111;
    step();
    idle(7);
    GlobalReset = 1'b1;
    step();
    GlobalReset = 1'b0;
    chk("rst_srdyi", {31'b0, dp_srdyi}, 32'd0);
    chk("rst_std", dp_std, 32'd0);
    idle(LAT + 4);
    ch_x = {$urandom, $urandom, $urandom};
    xs[0] = slice(0);
    ch_valid = 4'b0110 | 4'b0001;
    step();
    chk("rst_rr0", {11'b0, dp_x_adc}, {11'b0, xs[0]});
    idle(LAT + 2);

    // Random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      ch_x     = {$urandom, $urandom, $urandom};
      ch_valid = NCH'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) begin
        cfg_we   = 1'b1;
        cfg_ch   = 2'($urandom_range(0, 3));
        cfg_sel  = 1'($urandom_range(0, 1));
        cfg_data = $urandom;
      end
      ovf_clr = ($urandom_range(0, 19) == 0);
      if (n % 97 == 50) inj = 1'b1;
      step();
    end
    idle(LAT + 4);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/centscale_sched.md
# centscale_sched

Four-channel scheduler for the shared center/scale datapath (ieee-to-SMC conversion, two SMC multipliers, SMC adder; fixed 18-cycle latency). It buffers one pending ADC sample per channel and holds per-channel mean/std coefficients. A round-robin arbiter issues at most one sample per cycle into the datapath. A tag pipeline delays the coefficients to the multiplier stage and labels each result with its source channel.

## Interface
- NCH, 4: number of channels (channel index width 2).
- LATENCY, 18: datapath latency, `dp_srdyi` to `dp_srdyo`.
- CONV_LAT, 5: conversion-stage latency; coefficients must reach the multipliers this many cycles after `dp_srdyi`.
- STD_RST, 32'h3F800000: reset value of every std register.
- clk  in  1  clock
- GlobalReset  in  1  synchronous, active-high reset
- ch_x  in  NCH*21  ADC samples; channel i occupies bits [21i+20:21i]
- ch_valid  in  NCH  per-channel single-cycle sample strobe
- cfg_we  in  1  coefficient write strobe
- cfg_ch  in  2  channel to write
- cfg_sel  in  1  0 = mean, 1 = std
- cfg_data  in  32  SMC coefficient value
- ovf_clr  in  1  clears `overflow` and `err_sync`
- dp_x_adc  out  21  sample to datapath
- dp_srdyi  out  1  sample valid to datapath
- dp_mean  out  32  mean to datapath, delayed CONV_LAT cycles
- dp_std  out  32  std to datapath, delayed CONV_LAT cycles
- dp_x_centScale  in  32  datapath result
- dp_srdyo  in  1  datapath result valid
- y_o  out  32  registered result
- y_ch  out  2  source channel of `y_o`
- y_valid  out  1  result strobe
- overflow  out  NCH  sticky: a sample was dropped on that channel
- err_sync  out  1  sticky: `dp_srdyo` disagreed with the tag pipeline

## Operation
- **Reset.**
  - All outputs are 0.
  - Pending flags clear.
  - Round-robin pointer = 0.
  - Mean registers = 0; std registers = STD_RST.
  - Tag and coefficient delay lines flush.
  - A reset asserted mid-operation discards all in-flight tags. The datapath shares GlobalReset, so no stale result appears.
- **Capture.**
  - `ch_valid[i]` latches `ch_x` slice i into `buf[i]` and sets `pend[i]`.
  - If `pend[i]` is already set and channel i is not being issued that cycle: the new sample is dropped, the old one is kept, and `overflow[i]` is set.
  - If channel i is issued in the same cycle: the new sample is accepted.
- **Arbitration.**
  - Each cycle, search the pending channels for the first set, starting at pointer `rr`.
  - Winner w: register `buf[w]` to `dp_x_adc`, set `dp_srdyi` = 1, clear `pend[w]`, set `rr` = w+1 mod NCH.
  - No pending channel: `dp_srdyi` = 0, `dp_x_adc` holds its previous value, `rr` is unchanged.
- **Coefficients.**
  - `cfg_we` writes the selected register at the clock edge.
  - A sample uses the register values present on the cycle it is issued. A write in that same cycle affects only later issues.
  - The issued {mean, std} pair enters a CONV_LAT-deep delay line and drives `dp_mean`/`dp_std` at its output. The outputs hold the last pair when no issue is flowing.
- **Tagging.**
  - A LATENCY-deep shift register carries {`dp_srdyi`, channel}.
  - Each cycle: `y_o` ← `dp_x_centScale`, `y_valid` ← `dp_srdyo`, `y_ch` ← tag-output channel.
  - If `dp_srdyo` ≠ tag-output valid, `err_sync` is set. The result is still forwarded, with the tag channel.
- **Clear.** `ovf_clr` clears `overflow` and `err_sync`. If a set event occurs in the same cycle, the set wins.

## Timing
- `ch_valid` in cycle t → `pend` set after edge t → earliest `dp_srdyi` in cycle t+1 (registered).
- `dp_mean`/`dp_std` for that sample are valid in cycle t+1+CONV_LAT.
- `dp_srdyo` arrives in cycle t+1+LATENCY; `y_valid` follows in cycle t+2+LATENCY.
- Throughput: one sample per cycle aggregate. With all channels continuously pending, each channel is served once per NCH cycles.
- Worst-case wait for a pending sample is NCH−1 cycles. A channel strobing faster than once per NCH cycles under full load can overflow.

## Test plan
- **Single sample, post-reset.**
  - Stimulus: mean[0]=0x00000000, std[0]=0x3F800000; ch_valid=4'b0001 in cycle 0.
  - Response: `dp_srdyi` in cycle 1, `dp_std` = 0x3F800000 in cycle 6, `y_valid` with `y_ch`=0 in cycle 20.
- **All four channels strobed in cycle 0.**
  - Response: issue order 0,1,2,3 in cycles 1–4.
  - A second burst in cycle 5 issues 0,1,2,3 in cycles 6–9.
  - Results carry `y_ch` 0,1,2,3 in order.
- **Overflow.**
  - Stimulus: ch3 strobed in cycles 0 and 1 while ch0–2 are also pending.
  - Response: `overflow` = 4'b1000, the first ch3 sample is issued, the second is dropped.
  - `ovf_clr` then returns `overflow` to 0.
- **Coefficient write during issue.**
  - Stimulus: `cfg_we` to std[1] = 0x40000000 in the same cycle ch1 is issued.
  - Response: that sample sees the old std; the next ch1 sample sees 0x40000000 at `dp_std`.
- **Sync error.**
  - Stimulus: force `dp_srdyo` = 1 in a cycle with no tag valid.
  - Response: `err_sync` = 1 one cycle later and stays sticky until `ovf_clr`.
- **Reset mid-flight.**
  - Stimulus: issue samples in cycles 1–4, assert GlobalReset in cycle 8.
  - Response: all outputs 0, no `y_valid` for the flushed samples, `rr` = 0 afterward.
